// File: rtl/fetch_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : fetch_stage_if                                            |
// | Brief  : Bundle of the fetch-stage control, instruction-memory and |
// |          IF/ID pipeline-register signals.                          |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
interface fetch_stage_if;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        jump_en;
  logic [15:0] jump_target;
  logic [15:0] imem_instr;
  logic [15:0] imem_pc;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus2;
  logic        ifid_valid;
  logic        halted;

  // Pipeline/memory side: drives control and the fetched word, observes IF/ID.
  modport master (
    output stall, branch_taken, branch_target, jump_en, jump_target, imem_instr,
    input  imem_pc, ifid_instr, ifid_pc_plus2, ifid_valid, halted
  );

  // Fetch stage side.
  modport slave (
    input  stall, branch_taken, branch_target, jump_en, jump_target, imem_instr,
    output imem_pc, ifid_instr, ifid_pc_plus2, ifid_valid, halted
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : fetch_stage                                               |
// | Brief  : Instruction-fetch stage of the 16-bit MIPS pipeline. Owns |
// |          the PC, addresses the combinational instruction memory    |
// |          and fills the IF/ID register. Handles PC+2, branch/jump   |
// |          redirects, stalls and flushes.                            |
// | Option : FETCH_HALT_EN - fetching 16'hFFFF halts fetch until rst.  |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  wire logic     clk,
  input  wire logic     rst,
  fetch_stage_if.slave  bus
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [15:0] c_PC_STEP   = 16'd2;
  localparam logic [15:0] c_ALIGN     = 16'hFFFE;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_ifid_instr;
  logic [15:0] r_ifid_pc_plus2;
  logic        r_ifid_valid;

  logic        w_redirect;
  logic [15:0] w_redirect_target;
  logic [15:0] w_pc_plus2;
  logic        w_halt_hit;

  // Branch is the older instruction, so it beats a simultaneous jump.
  assign w_redirect        = bus.branch_taken | bus.jump_en;
  assign w_redirect_target = bus.branch_taken ? bus.branch_target : bus.jump_target;
  assign w_pc_plus2        = r_pc + c_PC_STEP;

`ifdef FETCH_HALT_EN
  localparam logic [15:0] c_HALT_OPCODE = 16'hFFFF;
  assign w_halt_hit  = (bus.imem_instr == c_HALT_OPCODE);
  assign bus.halted  = (r_state == HALT);
`else
  assign w_halt_hit  = 1'b0;
  assign bus.halted  = 1'b0;
`endif

  assign bus.imem_pc       = r_pc;
  assign bus.ifid_instr    = r_ifid_instr;
  assign bus.ifid_pc_plus2 = r_ifid_pc_plus2;
  assign bus.ifid_valid    = r_ifid_valid;

  // PC, IF/ID register and run/halt state; priority rst > halt > redirect > stall > sequential.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= RUN;
      r_pc            <= RESET_PC;
      r_ifid_instr    <= NOP_INSTR;
      r_ifid_pc_plus2 <= 16'h0000;
      r_ifid_valid    <= 1'b0;
    end else if (r_state == HALT) begin
      // PC frozen; control inputs ignored; keep feeding bubbles downstream.
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
    end else if (w_redirect) begin
      // Flush the wrong-path instruction; PC+2 of the slot is left as-is.
      r_pc         <= w_redirect_target & c_ALIGN;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
    end else if (!bus.stall) begin
      r_ifid_instr    <= bus.imem_instr;
      r_ifid_pc_plus2 <= w_pc_plus2;
      r_ifid_valid    <= 1'b1;
      if (w_halt_hit) begin
        // Halt word is delivered to ID but the PC stays on it.
        r_state <= HALT;
      end else begin
        r_pc <= w_pc_plus2;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_fetch_stage                                            |
// | Brief  : Self-checking bench for fetch_stage with a scoreboard of  |
// |          expected PC / IF/ID / halted values per clock edge.       |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module tb_fetch_stage;

  localparam logic [15:0] c_RESET_PC  = 16'h0000;
  localparam logic [15:0] c_NOP       = 16'h0000;
`ifdef FETCH_HALT_EN
  localparam bit c_HALT_EN = 1'b1;
`else
  localparam bit c_HALT_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pp2;
    logic        valid;
    logic        halted;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC  (c_RESET_PC),
    .NOP_INSTR (c_NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  bit   ffff_en  = 1'b0;
  exp_t m;
  exp_t sb_q[$];

  // Combinational instruction memory model.
  always_comb begin
    case (bus.imem_pc)
      16'h0000: bus.imem_instr = 16'h1111;
      16'h0002: bus.imem_instr = 16'h2222;
      16'h0004: bus.imem_instr = 16'h3333;
      16'h0008: bus.imem_instr = ffff_en ? 16'hFFFF : (16'h5A00 ^ bus.imem_pc);
      default:  bus.imem_instr = 16'h5A00 ^ bus.imem_pc;
    endcase
  end

  function automatic logic [15:0] mem_of(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1111;
      16'h0002: return 16'h2222;
      16'h0004: return 16'h3333;
      16'h0008: return ffff_en ? 16'hFFFF : (16'h5A00 ^ a);
      default:  return 16'h5A00 ^ a;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, act, exp);
    end
  endtask

  // One clock edge: drive inputs, predict the result, then compare against the scoreboard.
  task automatic step(input logic r, input logic s, input logic b, input logic [15:0] bt,
                      input logic j, input logic [15:0] jt);
    exp_t        e;
    logic [15:0] fetched;
    @(negedge clk);
    rst               = r;
    bus.stall         = s;
    bus.branch_taken  = b;
    bus.branch_target = bt;
    bus.jump_en       = j;
    bus.jump_target   = jt;
    fetched = mem_of(m.pc);
    e = m;
    if (r) begin
      e.pc = c_RESET_PC; e.instr = c_NOP; e.pp2 = 16'h0000; e.valid = 1'b0; e.halted = 1'b0;
    end else if (m.halted) begin
      e.instr = c_NOP; e.valid = 1'b0;
    end else if (b || j) begin
      e.pc = (b ? bt : jt) & 16'hFFFE; e.instr = c_NOP; e.valid = 1'b0;
    end else if (!s) begin
      e.instr = fetched; e.pp2 = m.pc + 16'd2; e.valid = 1'b1;
      if (c_HALT_EN && fetched == 16'hFFFF) e.halted = 1'b1;
      else e.pc = m.pc + 16'd2;
    end
    m = e;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 16'd1, 16'd0);
    end else begin
      e = sb_q.pop_front();
      check("pc",     bus.imem_pc,              e.pc);
      check("instr",  bus.ifid_instr,           e.instr);
      check("pp2",    bus.ifid_pc_plus2,        e.pp2);
      check("valid",  {15'd0, bus.ifid_valid},  {15'd0, e.valid});
      check("halted", {15'd0, bus.halted},      {15'd0, e.halted});
    end
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 16'h0;
    bus.jump_en = 1'b0; bus.jump_target = 16'h0;
    m = '{pc: 16'h0, instr: 16'h0, pp2: 16'h0, valid: 1'b0, halted: 1'b0};

    // Reset state, then sequential fetch.
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    check("rst_valid", {15'd0, bus.ifid_valid}, 16'd0);
    seq(1);
    check("first_fetch", bus.ifid_instr, 16'h1111);
    seq(1);
    // Two stalled cycles at pc=0x0004.
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    check("stall_pc", bus.imem_pc, 16'h0004);
    check("stall_instr", bus.ifid_instr, 16'h2222);
    check("stall_pp2", bus.ifid_pc_plus2, 16'h0004);
    seq(1);
    check("resume_instr", bus.ifid_instr, 16'h3333);
    check("resume_pc", bus.imem_pc, 16'h0006);

    // Branch + jump + stall together: branch wins, bit 0 cleared, flush.
    step(1'b0, 1'b1, 1'b1, 16'h0041, 1'b1, 16'h0100);
    check("redir_pc", bus.imem_pc, 16'h0040);
    check("redir_instr", bus.ifid_instr, c_NOP);
    seq(1);
    check("redir_valid", {15'd0, bus.ifid_valid}, 16'd1);

    // PC wrap from 0xFFFE.
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'hFFFE);
    seq(1);
    check("wrap_pc", bus.imem_pc, 16'h0000);
    check("wrap_pp2", bus.ifid_pc_plus2, 16'h0000);

    // Reset while stalled at 0x0020.
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0020);
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    check("midstall_rst_pc", bus.imem_pc, c_RESET_PC);

    // 0xFFFF at pc=0x0008.
    ffff_en = 1'b1;
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    seq(5);
    check("ffff_instr", bus.ifid_instr, 16'hFFFF);
`ifdef FETCH_HALT_EN
    check("halt_flag", {15'd0, bus.halted}, 16'd1);
    check("halt_pc", bus.imem_pc, 16'h0008);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0200);
    check("halt_jump_ignored", bus.imem_pc, 16'h0008);
    step(1'b0, 1'b1, 1'b1, 16'h0300, 1'b0, 16'h0);
    check("halt_bubble", {15'd0, bus.ifid_valid}, 16'd0);
`else
    check("no_halt_flag", {15'd0, bus.halted}, 16'd0);
    check("no_halt_pc", bus.imem_pc, 16'h000A);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0200);
`endif
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    check("halt_rst_flag", {15'd0, bus.halted}, 16'd0);
    check("halt_rst_pc", bus.imem_pc, 16'h0000);

    // Redirect in the same cycle as the 0xFFFF fetch: no halt.
    seq(4);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0030);
    check("redir_over_halt", bus.imem_pc, 16'h0030);
    seq(2);

    ffff_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
